sequenciador_notas: RTL and testbench

SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

---
 rtl/sequenciador_notas.sv | 175 +++++++++++++++++
 tb/tb_sequenciador_notas.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_notas.sv
// Melody sequencer: plays a 16-entry note memory, one entry per note,
// each note held for dur beats of BEAT_DIV clock cycles.
module sequenciador_notas #(
    parameter int unsigned BEAT_DIV = 12500000,
    parameter int unsigned LEN      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    output logic [2:0] nota,
    output logic       tom,
    output logic       note_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] step
);

    localparam int unsigned PW = $clog2(BEAT_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      mem_q [LEN];
    logic [2:0]      nota_q, nota_d;
    logic            tom_q, tom_d;
    logic [3:0]      step_q, step_d;
    logic [2:0]      rem_q, rem_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            nv_q, nv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [3:0]      next_step;
    logic [6:0]      next_entry;
    logic            tick;
    logic            seq_end;

    // Melody memory: cleared by reset, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (state_q == S_IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nota_q  <= '0;
            tom_q   <= 1'b0;
            step_q  <= '0;
            rem_q   <= '0;
            presc_q <= '0;
            nv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nota_q  <= nota_d;
            tom_q   <= tom_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            nv_q    <= nv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: playback sequencing, beat timing and output decode
    always_comb begin
        state_d    = state_q;
        nota_d     = nota_q;
        tom_d      = tom_q;
        step_d     = step_q;
        rem_d      = rem_q;
        presc_d    = presc_q;
        next_step  = step_q + 4'd1;
        next_entry = mem_q[next_step];
        tick       = (presc_q == PW'(BEAT_DIV - 1));
        seq_end    = (step_q == 4'(LEN - 1)) || (next_entry[6:4] == 3'd0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mem_q[0][6:4] != 3'd0) begin
                        state_d = S_PLAY;
                        step_d  = '0;
                        nota_d  = mem_q[0][2:0];
                        tom_d   = mem_q[0][3];
                        rem_d   = mem_q[0][6:4];
                        presc_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // The edge leaving PAUSE already counts, so a pause of N
            // cycles stretches the note by exactly N cycles.
            S_PLAY, S_PAUSE: begin
                if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_PLAY;
                    if (!tick) begin
                        presc_d = presc_q + 1'b1;
                    end else begin
                        presc_d = '0;
                        if (rem_q > 3'd1) begin
                            rem_d = rem_q - 3'd1;
                        end else if (!seq_end) begin
                            step_d = next_step;
                            nota_d = next_entry[2:0];
                            tom_d  = next_entry[3];
                            rem_d  = next_entry[6:4];
                        end else if (loop) begin
                            step_d = '0;
                            nota_d = mem_q[0][2:0];
                            tom_d  = mem_q[0][3];
                            rem_d  = mem_q[0][6:4];
                        end else begin
                            state_d = S_DONE;
                            rem_d   = '0;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE) begin
            nota_d  = '0;
            tom_d   = 1'b0;
            step_d  = '0;
            rem_d   = '0;
            presc_d = '0;
        end

        nv_d   = (state_d == S_PLAY) || (state_d == S_PAUSE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign nota       = nota_q;
    assign tom        = tom_q;
    assign step       = step_q;
    assign note_valid = nv_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Bench for sequenciador_notas: expected output traces are expanded
// directly from the melody contents (dur*BEAT cycles per entry).
module tb_sequenciador_notas;

    localparam int unsigned BEAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [6:0] wr_data;
    logic       start, stop, pause, loop;
    logic [2:0] nota;
    logic       tom, note_valid, busy, done;
    logic [3:0] step;

    sequenciador_notas #(.BEAT_DIV(BEAT), .LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop       (loop),
        .nota       (nota),
        .tom        (tom),
        .note_valid (note_valid),
        .busy       (busy),
        .done       (done),
        .step       (step)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] nota;
        logic       tom;
        logic [3:0] step;
        logic       nv;
        logic       busy;
        logic       done;
        logic       full;
    } exp_t;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [6:0]  model_mem [16];
    exp_t        q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_rec(input string tag, input exp_t e);
        if (e.full)
            chk(tag, 32'({nota, tom, step, note_valid, busy, done}),
                32'({e.nota, e.tom, e.step, e.nv, e.busy, e.done}));
        else
            chk(tag, 32'({note_valid, busy, done}), 32'({e.nv, e.busy, e.done}));
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] d, input bit track);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        if (track) model_mem[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Expected trace: every entry up to the first dur=0 (or entry 15)
    // shows for dur*BEAT cycles, repeated per pass, then a done cycle.
    task automatic build(input int unsigned passes, output int unsigned pass_len);
        exp_t e;
        q.delete();
        pass_len = 0;
        if (model_mem[0][6:4] != 3'd0) begin
            for (int unsigned p = 0; p < passes; p++) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    if (model_mem[i][6:4] == 3'd0) break;
                    for (int unsigned c = 0; c < BEAT * model_mem[i][6:4]; c++) begin
                        e = '{nota: model_mem[i][2:0], tom: model_mem[i][3], step: 4'(i),
                              nv: 1'b1, busy: 1'b1, done: 1'b0, full: 1'b1};
                        q.push_back(e);
                        if (p == 0) pass_len++;
                    end
                end
            end
        end
        e = '{nota: 3'd0, tom: 1'b0, step: 4'd0, nv: 1'b0, busy: 1'b1, done: 1'b1, full: 1'b0};
        q.push_back(e);
        e = '{nota: 3'd0, tom: 1'b0, step: 4'd0, nv: 1'b0, busy: 1'b0, done: 1'b0, full: 1'b1};
        q.push_back(e);
        q.push_back(e);
    endtask

    task automatic run(input string tag, input int unsigned passes, input int pause_at,
                       input int plen);
        int unsigned pass_len;
        int drop_idx;
        build(passes, pass_len);
        drop_idx = int'(pass_len * (passes - 1));
        if (pause_at >= 0) begin
            for (int k = 0; k < plen; k++) q.insert(pause_at + 1, q[pause_at]);
            if (pause_at < drop_idx) drop_idx += plen;
        end
        @(negedge clk);
        start = 1'b1;
        loop  = (passes > 1);
        for (int idx = 0; idx < q.size(); idx++) begin
            @(negedge clk);
            start = 1'b0;
            chk_rec($sformatf("%s[%0d]", tag, idx), q[idx]);
            if (passes > 1 && idx == drop_idx) loop = 1'b0;
            if (pause_at >= 0 && idx == pause_at) pause = 1'b1;
            if (pause_at >= 0 && idx == pause_at + plen) pause = 1'b0;
        end
        pause = 1'b0;
        loop  = 1'b0;
    endtask

    initial begin
        int unsigned len, passes;
        int          pat, plen;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;

        #12;
        chk("reset_outputs", 32'({nota, tom, step, note_valid, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Memory cleared by reset: start finishes immediately
        run("empty_start", 1, -1, 0);

        // Basic program: {1,0,3}, {2,1,5}, end marker
        wr(4'd0, {3'd1, 1'b0, 3'd3}, 1'b1);
        wr(4'd1, {3'd2, 1'b1, 3'd5}, 1'b1);
        wr(4'd2, 7'd0, 1'b1);
        run("basic", 1, -1, 0);
        run("loop", 3, -1, 0);
        run("pause", 1, 1, 10);

        // Stop mid-note, with a write attempted during playback
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'h7F;
        @(negedge clk); wr_en = 1'b0;
        chk("play_mid", 32'({nota, tom, step, note_valid, busy, done}),
            32'({3'd3, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0}));
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("stop_idle", 32'({nota, tom, step, note_valid, busy, done}), 32'd0);
        run("after_stop", 1, -1, 0);

        // Full depth: 16 entries of one beat, no wrap without loop
        for (int i = 0; i < 16; i++) wr(4'(i), {3'd1, 1'($urandom), 3'($urandom)}, 1'b1);
        run("full_depth", 1, -1, 0);
        run("full_loop", 2, -1, 0);

        // Randomized melodies
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                if (i < int'(len))
                    wr(4'(i), {3'($urandom_range(1, 3)), 1'($urandom), 3'($urandom)}, 1'b1);
                else
                    wr(4'(i), 7'd0, 1'b1);
            end
            passes = $urandom_range(1, 2);
            pat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            plen = int'($urandom_range(1, 5));
            run($sformatf("rand%0d", r), passes, pat, plen);
        end

        // Asynchronous reset mid-note
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({nota, tom, step, note_valid, busy, done}), 32'd0);
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        @(negedge clk); rst_n = 1'b1;
        run("reset_empty", 1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
